// File: rtl/acc.sv
// Single-register accumulator: loads acc_in on write-enabled clock edges.
// The zero and sign flags are decoded combinationally from the stored value.
module acc #(
  parameter int WIDTH = 11
) (
  input  logic             clock,
  input  logic             acc_reset,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             acc_wr,
  output logic [WIDTH-1:0] acc_out,
  output logic             acc_zero,
  output logic             acc_neg
);

  logic [WIDTH-1:0] r_acc;

  // An unknown write enable poisons the register so X sources stay visible in simulation.
  always_ff @(posedge clock or negedge acc_reset) begin
    if (!acc_reset) begin
      r_acc <= '0;
    end else if (acc_wr) begin
      r_acc <= acc_in;
    end else if (!acc_wr) begin
      r_acc <= r_acc;
    end else begin
      r_acc <= 'x;
    end
  end

  assign acc_out  = r_acc;
  assign acc_zero = (r_acc == '0);
  assign acc_neg  = r_acc[WIDTH-1];

endmodule

// File: tb/tb_acc.sv
// Scoreboard bench for acc: stimulus queues expected register/flag values,
// a free-running monitor pops and compares them against the DUT outputs.
module tb_acc;

  localparam int WIDTH = 11;

  logic             clock;
  logic             acc_reset;
  logic [WIDTH-1:0] acc_in;
  logic             acc_wr;
  logic [WIDTH-1:0] acc_out;
  logic             acc_zero;
  logic             acc_neg;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             neg;
    string            name;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  acc #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .acc_reset(acc_reset),
    .acc_in   (acc_in),
    .acc_wr   (acc_wr),
    .acc_out  (acc_out),
    .acc_zero (acc_zero),
    .acc_neg  (acc_neg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input logic rst, input logic wr, input logic [WIDTH-1:0] din);
    acc_reset = rst;
    acc_wr    = wr;
    acc_in    = din;
  endtask

  task automatic checkOutput(input logic [WIDTH-1:0] out, input logic zero, input logic neg,
                             input string name);
    exp_t e;
    e.out  = out;
    e.zero = zero;
    e.neg  = neg;
    e.name = name;
    expQ.push_back(e);
  endtask

  // Monitor polls between clock edges and checks every queued expectation.
  initial begin
    exp_t e;
    forever begin
      #1;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (acc_out === e.out) passes++;
        else $display("[TB] FAIL %s out: got %b expected %b", e.name, acc_out, e.out);
        checks++;
        if (acc_zero === e.zero) passes++;
        else $display("[TB] FAIL %s zero: got %b expected %b", e.name, acc_zero, e.zero);
        checks++;
        if (acc_neg === e.neg) passes++;
        else $display("[TB] FAIL %s neg: got %b expected %b", e.name, acc_neg, e.neg);
      end
    end
  end

  initial begin
    // Reset held with no clock edge yet
    applyStimulus(1'b0, 1'b0, 11'b00000110010);
    #3;
    checkOutput(11'b00000000000, 1'b1, 1'b0, "reset");

    // Release and load a positive value
    @(negedge clock);
    applyStimulus(1'b1, 1'b1, 11'b00000110010);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 11'b10110010010);
    checkOutput(11'b00000110010, 1'b0, 1'b0, "load");

    // Hold over several edges with a changed input and a mid-cycle write glitch
    for (int i = 0; i < 3; i++) begin
      #2 acc_wr = 1'b1;
      #1 acc_wr = 1'b0;
      @(negedge clock);
      checkOutput(11'b00000110010, 1'b0, 1'b0, "hold");
    end

    // Negative load
    applyStimulus(1'b1, 1'b1, 11'b10110010010);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 11'b10110010010);
    checkOutput(11'b10110010010, 1'b0, 1'b1, "negload");

    // Asynchronous reset between edges
    #3 acc_reset = 1'b0;
    #1 checkOutput(11'b00000000000, 1'b1, 1'b0, "asyncrst");

    // Reset held across an edge with new data
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 11'b11100000011);
    @(negedge clock);
    checkOutput(11'b00000000000, 1'b1, 1'b0, "rsthold");

    // Reset has priority over write
    applyStimulus(1'b0, 1'b1, 11'b11100000011);
    @(negedge clock);
    checkOutput(11'b00000000000, 1'b1, 1'b0, "rstprio");

    // Release with write pending
    applyStimulus(1'b1, 1'b1, 11'b11100000011);
    @(negedge clock);
    checkOutput(11'b11100000011, 1'b0, 1'b1, "release");

    // Back-to-back writes, including all-ones and zero boundaries
    applyStimulus(1'b1, 1'b1, 11'b00000000001);
    @(negedge clock);
    checkOutput(11'b00000000001, 1'b0, 1'b0, "b2b_1");
    applyStimulus(1'b1, 1'b1, 11'b10000000000);
    @(negedge clock);
    checkOutput(11'b10000000000, 1'b0, 1'b1, "b2b_2");
    applyStimulus(1'b1, 1'b1, 11'b11111111111);
    @(negedge clock);
    checkOutput(11'b11111111111, 1'b0, 1'b1, "b2b_ones");
    applyStimulus(1'b1, 1'b1, 11'b00000000000);
    @(negedge clock);
    checkOutput(11'b00000000000, 1'b1, 1'b0, "b2b_zero");
    applyStimulus(1'b1, 1'b0, 11'b01111111111);
    @(negedge clock);
    checkOutput(11'b00000000000, 1'b1, 1'b0, "b2b_hold");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && expQ.size() > 0; i++) #1;
    if (expQ.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/acc.md
ACC -- requirements
Module: acc

Interface
REQ-001 Parameter: WIDTH, default 11, data width of the accumulator in bits; all data ports SHALL scale with WIDTH.
REQ-002 Port: clock  input  1  single system clock; all state changes on its rising edge except reset.
REQ-003 Port: acc_reset  input  1  reset, asynchronous and active-low.
REQ-004 Port: acc_in  input  WIDTH  data to be loaded into the accumulator.
REQ-005 Port: acc_wr  input  1  write enable, active-high.
REQ-006 Port: acc_out  output  WIDTH  current accumulator contents, driven directly from the register.
REQ-007 Port: acc_zero  output  1  high when acc_out equals all zeros.
REQ-008 Port: acc_neg  output  1  equals acc_out[WIDTH-1], the two's-complement sign bit.
REQ-009 The block SHALL contain exactly one WIDTH-bit storage register and no other sequential state.

Function
REQ-010 Load: on a rising clock edge with acc_reset=1 and acc_wr=1, the register SHALL capture acc_in.
REQ-011 Latency: the loaded value SHALL appear on acc_out immediately after that edge, with one-cycle write latency.
REQ-012 Hold: on a rising edge with acc_wr=0, the register SHALL retain its value.
REQ-013 Hold: changes on acc_in while acc_wr=0 SHALL NOT affect acc_out.
REQ-014 acc_in and acc_wr SHALL be sampled only at the rising edge; glitches between edges SHALL have no effect.
REQ-015 Consecutive writes: back-to-back edges with acc_wr=1 SHALL load each new acc_in in turn, with no bubble cycle.
REQ-016 Flags: acc_zero and acc_neg SHALL be purely combinational functions of the register contents, with no extra cycle of delay.
REQ-017 Data path: no arithmetic, truncation or sign extension; acc_in SHALL be stored bit-exact.
REQ-018 X-handling: if acc_wr is unknown at an edge, the simulation model SHALL drive acc_out to X and SHALL NOT silently hold.

Reset
REQ-019 When acc_reset=0, the register SHALL clear to all zeros immediately, independent of clock.
REQ-020 During reset, acc_out SHALL be 0, acc_zero SHALL be 1 and acc_neg SHALL be 0.
REQ-021 While acc_reset=0, reset SHALL override acc_wr; simultaneous write and reset SHALL yield 0.
REQ-022 Reset release: the first rising edge with acc_reset=1 SHALL apply normal load/hold rules.
REQ-023 No reset synchronizer SHALL be included inside the block; release timing is the system's responsibility.
REQ-024 Reset asserted mid-operation, i.e. between a write and the next edge, SHALL discard the held value.

Verification
REQ-025 Scenario, reset: acc_reset=0 with acc_in=11'b00000110010 and acc_wr=0 -> acc_out=0, acc_zero=1, acc_neg=0, no clock needed.
REQ-026 Scenario, load: release reset, acc_wr=1, acc_in=11'b00000110010 for one edge -> acc_out=11'b00000110010, acc_zero=0, acc_neg=0 after that edge.
REQ-027 Scenario, hold: acc_wr=0, acc_in changed to 11'b10110010010 over several edges -> acc_out stays 11'b00000110010.
REQ-028 Scenario, negative load: acc_wr=1 for one edge with acc_in=11'b10110010010 -> acc_out=11'b10110010010, acc_neg=1, acc_zero=0.
REQ-029 Scenario, async reset mid-hold: pulse acc_reset=0 between edges -> acc_out=0 at once.
REQ-030 Scenario, reset continued: after REQ-029, acc_in=11'b11100000011 with acc_wr=0 -> acc_out remains 0.
REQ-031 Scenario, reset priority: acc_reset=0 and acc_wr=1 together over an edge -> acc_out=0.
REQ-032 Scenario, reset release: release acc_reset and apply the next edge with acc_wr=1 -> acc_out=11'b11100000011.
